fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch control and IF/ID pipeline register of the five-stage RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, captures the returned instruction with its PC into the IF/ID register, and applies stall, flush and redirect requests from the hazard unit and execute stage. Also detects fetches from misaligned or out-of-range PCs and parks fetch in a fault state.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; legal PCs are 0 .. IMEM_DEPTH*4-4
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- o_imem_address  out  32  current PC, combinationally equal to PC register
- i_imem_instruction  in  32  instruction word from memory for o_imem_address, same cycle
- i_stall  in  1  hold PC and IF/ID contents
- i_flush  in  1  replace IF/ID contents with a bubble
- i_redirect  in  1  load PC from i_redirect_pc (taken branch, jump, mispredict, trap)
- i_redirect_pc  in  32  redirect target
- o_if_id_valid  out  1  IF/ID holds a real instruction
- o_if_id_instruction  out  32  captured instruction; 32'h0000_0013 (NOP) when bubble
- o_if_id_pc  out  32  PC of captured instruction
- o_if_id_pc_plus4  out  32  o_if_id_pc + 4
- o_if_id_pred_taken  out  1  fetch predicted this instruction taken
- o_fetch_fault  out  1  fetch parked in FAULT
- o_fault_pc  out  32  offending PC

## Operation
- States: RUN, FAULT. Reset enters RUN.
- PC legal iff pc[1:0]==0 and pc < IMEM_DEPTH*4.
- Priority each edge: i_rst > i_redirect > fault detection > i_stall > normal advance; i_flush applies to IF/ID independently.
- RUN, normal: IF/ID <= {valid=1, i_imem_instruction, pc, pc+4, pred}; PC <= next_pc (pc+4 or predicted target).
- RUN, PC illegal and no redirect: IF/ID <= bubble; o_fault_pc <= pc; state <= FAULT; PC held. Applies even under i_stall.
- i_stall (RUN, PC legal, no redirect): PC and IF/ID unchanged, unless i_flush, which bubbles IF/ID.
- i_redirect (any state): PC <= i_redirect_pc; IF/ID <= bubble; state <= RUN; o_fetch_fault clears. Illegal targets fault on the following cycle.
- i_flush without redirect: IF/ID <= bubble; PC per stall/advance rules.
- FAULT: PC held, IF/ID bubble, o_fetch_fault=1; left only by i_redirect or i_rst.
- Bubble: valid=0, instruction=32'h0000_0013, pc and pc_plus4 fields = 0, pred=0.
- PC arithmetic modulo 2^32; 0xFFFF_FFFC+4 wraps to 0 (already out of range for any IMEM_DEPTH below 2^30).

## Timing
- o_imem_address combinational from PC register; instruction assumed valid same cycle.
- Fetch-to-IF/ID latency: 1 cycle. Redirect penalty: 1 bubble (redirect cycle's fetch discarded).
- Reset values: PC=RESET_PC, state RUN, o_if_id_valid=0, o_if_id_instruction=32'h0000_0013, o_if_id_pc=0, o_if_id_pc_plus4=0, o_if_id_pred_taken=0, o_fetch_fault=0, o_fault_pc=0.
- Reset asserted mid-stall, mid-fault or with redirect: reset wins, all values above.
- o_fetch_fault rises the edge after an illegal PC is presented; falls the edge after redirect.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: on a normal RUN advance, instruction opcode 7'b1101111 (JAL) -> next_pc = pc + J-immediate, pred=1; opcode 7'b1100011 with imm[12]=1 (backward branch) -> next_pc = pc + B-immediate, pred=1; otherwise pc+4, pred=0. Predicted targets pass through normal legality check.
- Undefined: next_pc always pc+4, o_if_id_pred_taken tied 0, no decode logic.

## Test plan
- Reset then 4 free-running cycles, memory words 0..3 = distinct values -> IF/ID shows words 0..3 with pc 0,4,8,12, valid=1 from cycle 1.
- i_stall high 2 cycles at PC=8 -> o_imem_address stays 8, IF/ID holds pc 4 contents; resumes with pc 8.
- i_redirect to 0x40 with i_stall high -> next cycle PC=0x40, valid=0; following cycle IF/ID pc=0x40.
- Redirect to 0x42 -> one cycle later o_fetch_fault=1, o_fault_pc=0x42, bubbles persist; redirect to 0x10 clears fault.
- PC reaches IMEM_DEPTH*4 (0x400) -> FAULT, o_fault_pc=0x400; i_rst mid-fault -> all reset values, PC=RESET_PC.
- With FETCH_STATIC_PREDICT_EN, at pc 0x20 fetch 32'hFE00_0EE3 (beq x0,x0,-4) -> next PC 0x1C, o_if_id_pred_taken=1; without macro next PC 0x24, pred=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch unit's memory, control and IF/ID signals.
//   master modport: the fetch unit (drives o_* signals, samples i_* signals).
//   slave modport:  the surrounding core / memory (the opposite directions).
// Signals:
//   o_imem_address / i_imem_instruction  combinational instruction memory port
//   i_stall, i_flush, i_redirect, i_redirect_pc  hazard-unit / execute controls
//   o_if_id_*                            IF/ID pipeline register contents
//   o_fetch_fault, o_fault_pc            fetch fault status
interface fetch_unit_if;
  logic [31:0] o_imem_address;
  logic [31:0] i_imem_instruction;
  logic        i_stall;
  logic        i_flush;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_if_id_valid;
  logic [31:0] o_if_id_instruction;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_pc_plus4;
  logic        o_if_id_pred_taken;
  logic        o_fetch_fault;
  logic [31:0] o_fault_pc;

  modport master (
    output o_imem_address,
    input  i_imem_instruction,
    input  i_stall,
    input  i_flush,
    input  i_redirect,
    input  i_redirect_pc,
    output o_if_id_valid,
    output o_if_id_instruction,
    output o_if_id_pc,
    output o_if_id_pc_plus4,
    output o_if_id_pred_taken,
    output o_fetch_fault,
    output o_fault_pc
  );

  modport slave (
    input  o_imem_address,
    output i_imem_instruction,
    output i_stall,
    output i_flush,
    output i_redirect,
    output i_redirect_pc,
    input  o_if_id_valid,
    input  o_if_id_instruction,
    input  o_if_id_pc,
    input  o_if_id_pc_plus4,
    input  o_if_id_pred_taken,
    input  o_fetch_fault,
    input  o_fault_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch control and IF/ID pipeline register.
// Owns the PC, presents it to a combinational instruction memory, captures the
// returned word into IF/ID, and applies stall / flush / redirect. A misaligned
// or out-of-range PC parks fetch in StFault until a redirect or reset.
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_rst    synchronous active-high reset
//   fetch    fetch_unit_if.master (memory port, controls, IF/ID, fault status)
// Parameters:
//   RESET_PC    PC loaded by reset
//   IMEM_DEPTH  memory depth in 32-bit words; legal PCs are 0 .. IMEM_DEPTH*4-4
// Build option:
//   FETCH_STATIC_PREDICT_EN  predicts JAL and backward conditional branches taken
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_unit_if.master fetch
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred;
  } if_id_t;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam if_id_t Bubble = '{valid: 1'b0, instr: Nop, pc: 32'h0, pc_plus4: 32'h0,
                                pred: 1'b0};
  // 33 bits so IMEM_DEPTH*4 == 2^32 cannot overflow the comparison.
  localparam logic [32:0] PcLimit = 33'(IMEM_DEPTH) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  if_id_t      if_id_q, if_id_d;

  logic        pc_legal;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} < PcLimit);

`ifdef FETCH_STATIC_PREDICT_EN
  logic [31:0] instr;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign instr = fetch.i_imem_instruction;
  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    next_pc = pc_plus4;
    pred    = 1'b0;
    if (instr[6:0] == 7'b1101111) begin
      next_pc = pc_q + j_imm;
      pred    = 1'b1;
    end else if (instr[6:0] == 7'b1100011 && instr[31]) begin
      // Sign bit set means a backward branch: loop-closing, predicted taken.
      next_pc = pc_q + b_imm;
      pred    = 1'b1;
    end
  end
`else
  assign next_pc = pc_plus4;
  assign pred    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    if_id_d    = if_id_q;

    if (fetch.i_redirect) begin
      // Fetch in the redirect cycle is discarded; target legality is checked next cycle.
      pc_d    = fetch.i_redirect_pc;
      if_id_d = Bubble;
      state_d = StRun;
    end else if (state_q == StFault) begin
      if_id_d = Bubble;
    end else if (!pc_legal) begin
      // Faulting takes precedence over stall so a stalled bad PC still reports.
      if_id_d    = Bubble;
      fault_pc_d = pc_q;
      state_d    = StFault;
    end else if (fetch.i_stall) begin
      if (fetch.i_flush) if_id_d = Bubble;
    end else begin
      if_id_d = '{valid: 1'b1, instr: fetch.i_imem_instruction, pc: pc_q,
                  pc_plus4: pc_plus4, pred: pred};
      pc_d    = next_pc;
      if (fetch.i_flush) if_id_d = Bubble;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'h0;
      if_id_q    <= Bubble;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      if_id_q    <= if_id_d;
    end
  end

  assign fetch.o_imem_address      = pc_q;
  assign fetch.o_if_id_valid       = if_id_q.valid;
  assign fetch.o_if_id_instruction = if_id_q.instr;
  assign fetch.o_if_id_pc          = if_id_q.pc;
  assign fetch.o_if_id_pc_plus4    = if_id_q.pc_plus4;
  assign fetch.o_if_id_pred_taken  = if_id_q.pred;
  assign fetch.o_fetch_fault       = (state_q == StFault);
  assign fetch.o_fault_pc          = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Each driven cycle pushes the
// expected post-edge state from a behavioural model; after the edge the entry is
// popped and compared. Directed checks pin down the documented scenarios.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc   = 32'h0000_0000;
  localparam int unsigned ImemDepth = 256;
  localparam logic [31:0] Nop       = 32'h0000_0013;

  logic clk;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (ResetPc),
    .IMEM_DEPTH (ImemDepth)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .fetch (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: addi-style words (never predicted) except two control ops.
  logic [31:0] imem [ImemDepth];
  initial begin
    for (int i = 0; i < int'(ImemDepth); i++) imem[i] = {i[19:0], 12'h013};
    imem[8]  = 32'hFE00_0EE3;  // 0x20: beq x0,x0,-4
    imem[48] = 32'h0100_006F;  // 0xC0: jal x0,+16
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < ImemDepth * 4) return imem[addr[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.i_imem_instruction = mem_word(bus.o_imem_address);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        fault;
    logic [31:0] fpc;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];

  // Model state
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fpc;
  logic        m_valid, m_pred;
  logic [31:0] m_instr, m_ipc, m_ipc4;

  task automatic model_bubble();
    m_valid = 1'b0; m_instr = Nop; m_ipc = 32'h0; m_ipc4 = 32'h0; m_pred = 1'b0;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             output logic pr);
    pr = 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
    if (ins[6:0] == 7'h6F) begin
      pr = 1'b1;
      return pc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    end
    if (ins[6:0] == 7'h63 && ins[31]) begin
      pr = 1'b1;
      return pc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    end
`endif
    return pc + 32'd4;
  endfunction

  task automatic model_step(input logic r, input logic st, input logic fl, input logic rd,
                            input logic [31:0] rpc);
    exp_t        e;
    logic        pr;
    logic [31:0] nxt;
    if (r) begin
      m_pc = ResetPc; m_fault = 1'b0; m_fpc = 32'h0; model_bubble();
    end else if (rd) begin
      m_pc = rpc; m_fault = 1'b0; model_bubble();
    end else if (m_fault) begin
      model_bubble();
    end else if (m_pc[1:0] != 2'b00 || m_pc >= ImemDepth * 4) begin
      m_fpc = m_pc; m_fault = 1'b1; model_bubble();
    end else if (st) begin
      if (fl) model_bubble();
    end else begin
      nxt = model_next(m_pc, mem_word(m_pc), pr);
      m_valid = 1'b1; m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
      m_pred = pr; m_pc = nxt;
      if (fl) model_bubble();
    end
    e = '{valid: m_valid, instr: m_instr, pc: m_ipc, pc4: m_ipc4, pred: m_pred,
          fault: m_fault, fpc: m_fpc, addr: m_pc};
    sb_q.push_back(e);
  endtask

  task automatic do_cycle(input logic r, input logic st, input logic fl, input logic rd,
                          input logic [31:0] rpc);
    exp_t e;
    rst = r; bus.i_stall = st; bus.i_flush = fl; bus.i_redirect = rd; bus.i_redirect_pc = rpc;
    model_step(r, st, fl, rd, rpc);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("valid",  {31'h0, bus.o_if_id_valid},      {31'h0, e.valid});
    check_eq("instr",  bus.o_if_id_instruction,         e.instr);
    check_eq("if_pc",  bus.o_if_id_pc,                  e.pc);
    check_eq("if_pc4", bus.o_if_id_pc_plus4,            e.pc4);
    check_eq("pred",   {31'h0, bus.o_if_id_pred_taken}, {31'h0, e.pred});
    check_eq("fault",  {31'h0, bus.o_fetch_fault},      {31'h0, e.fault});
    check_eq("fpc",    bus.o_fault_pc,                  e.fpc);
    check_eq("addr",   bus.o_imem_address,              e.addr);
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] targets [8];
    targets = '{32'h0, 32'h20, 32'hC0, 32'h3FC, 32'h42, 32'h400, 32'h1C, 32'h100};
    m_pc = ResetPc; m_fault = 1'b0; m_fpc = 32'h0; model_bubble();

    // Reset state
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("rst_valid", {31'h0, bus.o_if_id_valid}, 32'h0);
    check_eq("rst_instr", bus.o_if_id_instruction, Nop);
    check_eq("rst_addr", bus.o_imem_address, ResetPc);

    // Free run: words 0..3
    run_free(4);
    check_eq("run_pc12", bus.o_if_id_pc, 32'hC);
    check_eq("run_word3", bus.o_if_id_instruction, 32'h0000_3013);

    // Stall two cycles at PC=8
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run_free(2);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("stall_addr", bus.o_imem_address, 32'h8);
      check_eq("stall_ifpc", bus.o_if_id_pc, 32'h4);
    end
    run_free(1);
    check_eq("resume_ifpc", bus.o_if_id_pc, 32'h8);

    // Flush while advancing
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("flush_valid", {31'h0, bus.o_if_id_valid}, 32'h0);
    check_eq("flush_addr", bus.o_imem_address, 32'h10);

    // Redirect beats stall
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    check_eq("redir_addr", bus.o_imem_address, 32'h40);
    check_eq("redir_valid", {31'h0, bus.o_if_id_valid}, 32'h0);
    run_free(1);
    check_eq("redir_ifpc", bus.o_if_id_pc, 32'h40);

    // Misaligned redirect target faults, then recovers
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
    check_eq("mis_nofault", {31'h0, bus.o_fetch_fault}, 32'h0);
    run_free(1);
    check_eq("mis_fault", {31'h0, bus.o_fetch_fault}, 32'h1);
    check_eq("mis_fpc", bus.o_fault_pc, 32'h42);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_free(1);
    check_eq("mis_bubble", {31'h0, bus.o_if_id_valid}, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    check_eq("mis_clear", {31'h0, bus.o_fetch_fault}, 32'h0);
    run_free(1);
    check_eq("mis_resume", bus.o_if_id_pc, 32'h10);

    // Run off the end of memory, then reset mid-fault with stall and redirect
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3F8);
    run_free(3);
    check_eq("oor_fault", {31'h0, bus.o_fetch_fault}, 32'h1);
    check_eq("oor_fpc", bus.o_fault_pc, 32'h400);
    run_free(1);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
    check_eq("rstf_addr", bus.o_imem_address, ResetPc);
    check_eq("rstf_fault", {31'h0, bus.o_fetch_fault}, 32'h0);
    check_eq("rstf_fpc", bus.o_fault_pc, 32'h0);

    // Static prediction: backward branch and JAL
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    run_free(1);
`ifdef FETCH_STATIC_PREDICT_EN
    check_eq("br_next", bus.o_imem_address, 32'h1C);
    check_eq("br_pred", {31'h0, bus.o_if_id_pred_taken}, 32'h1);
`else
    check_eq("br_next", bus.o_imem_address, 32'h24);
    check_eq("br_pred", {31'h0, bus.o_if_id_pred_taken}, 32'h0);
`endif
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hC0);
    run_free(1);
`ifdef FETCH_STATIC_PREDICT_EN
    check_eq("jal_next", bus.o_imem_address, 32'hD0);
`else
    check_eq("jal_next", bus.o_imem_address, 32'hC4);
`endif

    // Random mix of controls
    for (int i = 0; i < 80; i++) begin
      do_cycle(($urandom % 30) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
               ($urandom % 8) == 0, targets[$urandom % 8]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
